// File: rtl/lfsr_rng_multi.sv
// Multi-channel Galois LFSR random source with warm-up, decimation by STEPS and a valid/ready output.
// Build option LFSR_RNG_LEAP_EN: apply all STEPS shifts in one cycle (one word per advancing cycle).
module lfsr_rng_multi #(
  parameter int unsigned    LEN         = 16,
  parameter logic [LEN-1:0] TAPS        = 16'hB400,
  parameter int unsigned    CHANNELS    = 4,
  parameter int unsigned    OUT_W       = 8,
  parameter int unsigned    STEPS       = 8,
  parameter int unsigned    WARMUP      = 32,
  parameter logic [LEN-1:0] SEED_STRIDE = 16'h9E37
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      reseed,
  input  logic [LEN-1:0]            seed,
  input  logic                      out_ready,
  output logic                      out_valid,
  output logic [CHANNELS*OUT_W-1:0] out_data,
  output logic                      warm,
  output logic                      lockup
);

  localparam int unsigned DW  = CHANNELS * OUT_W;
  localparam int unsigned SCW = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam int unsigned WCW = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;

  typedef enum logic {ST_WARM, ST_RUN} state_t;

  state_t           state_q, state_d;
  logic [LEN-1:0]   lfsr_q [CHANNELS];
  logic [LEN-1:0]   lfsr_d [CHANNELS];
  logic [SCW-1:0]   step_cnt_q, step_cnt_d;
  logic [WCW-1:0]   warm_cnt_q, warm_cnt_d;
  logic             out_valid_d;
  logic [DW-1:0]    out_data_d;
  logic             lockup_d;
  logic             any_zero;
  logic             xfer;
  logic             adv;

  function automatic logic [LEN-1:0] lfsr_step(input logic [LEN-1:0] s);
    return {1'b0, s[LEN-1:1]} ^ (s[0] ? TAPS : '0);
  endfunction

  // Per-channel seed: zero seed selects all-ones; a zero result is also forced to all-ones
  function automatic logic [LEN-1:0] seed_of(input logic [LEN-1:0] sd, input int unsigned k);
    logic [LEN-1:0] base;
    logic [LEN-1:0] v;
    base = (sd == '0) ? '1 : sd;
    v    = base ^ (LEN'(k) * SEED_STRIDE);
    return (v == '0) ? '1 : v;
  endfunction

`ifdef LFSR_RNG_LEAP_EN
  int unsigned rem;
  int unsigned shifts;

  // Unrolled STEPS-deep chain; only the first n stages take effect
  function automatic logic [LEN-1:0] lfsr_leap(input logic [LEN-1:0] s, input int unsigned n);
    logic [LEN-1:0] v;
    v = s;
    for (int unsigned i = 0; i < STEPS; i++) begin
      if (i < n) v = lfsr_step(v);
    end
    return v;
  endfunction
`endif

  assign xfer = out_valid && out_ready;
  assign adv  = en && (!out_valid || out_ready);

  always_comb begin
    state_d     = state_q;
    lfsr_d      = lfsr_q;
    step_cnt_d  = step_cnt_q;
    warm_cnt_d  = warm_cnt_q;
    out_valid_d = out_valid;
    out_data_d  = out_data;
    lockup_d    = lockup;
    any_zero    = 1'b0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (lfsr_q[k] == '0) any_zero = 1'b1;
    end
`ifdef LFSR_RNG_LEAP_EN
    rem    = WARMUP - 32'(warm_cnt_q);
    shifts = (rem < STEPS) ? rem : STEPS;
`endif

    if (rst || reseed) begin
      for (int k = 0; k < CHANNELS; k++) lfsr_d[k] = seed_of(seed, k);
      step_cnt_d  = '0;
      warm_cnt_d  = '0;
      out_valid_d = 1'b0;
      out_data_d  = '0;
      lockup_d    = rst ? 1'b0 : lockup;
      state_d     = (WARMUP > 0) ? ST_WARM : ST_RUN;
    end else if (any_zero) begin
      // all-zero is a fixed point of the step; repair it before anything else moves
      for (int k = 0; k < CHANNELS; k++) begin
        if (lfsr_q[k] == '0) lfsr_d[k] = '1;
      end
      lockup_d = 1'b1;
      if (xfer) out_valid_d = 1'b0;
    end else begin
      if (xfer) out_valid_d = 1'b0;
      case (state_q)
        ST_WARM: begin
          if (en) begin
`ifdef LFSR_RNG_LEAP_EN
            for (int k = 0; k < CHANNELS; k++) lfsr_d[k] = lfsr_leap(lfsr_q[k], shifts);
            warm_cnt_d = warm_cnt_q + WCW'(shifts);
            if (rem <= STEPS) begin
              state_d    = ST_RUN;
              step_cnt_d = '0;
            end
`else
            for (int k = 0; k < CHANNELS; k++) lfsr_d[k] = lfsr_step(lfsr_q[k]);
            warm_cnt_d = warm_cnt_q + WCW'(1);
            if (warm_cnt_q == WCW'(WARMUP - 1)) begin
              state_d    = ST_RUN;
              step_cnt_d = '0;
            end
`endif
          end
        end
        default: begin
          if (adv) begin
`ifdef LFSR_RNG_LEAP_EN
            for (int k = 0; k < CHANNELS; k++) begin
              lfsr_d[k] = lfsr_leap(lfsr_q[k], STEPS);
              out_data_d[k*OUT_W +: OUT_W] = lfsr_d[k][OUT_W-1:0];
            end
            step_cnt_d  = '0;
            out_valid_d = 1'b1;
`else
            for (int k = 0; k < CHANNELS; k++) lfsr_d[k] = lfsr_step(lfsr_q[k]);
            if (step_cnt_q == SCW'(STEPS - 1)) begin
              step_cnt_d  = '0;
              out_valid_d = 1'b1;
              for (int k = 0; k < CHANNELS; k++) begin
                out_data_d[k*OUT_W +: OUT_W] = lfsr_d[k][OUT_W-1:0];
              end
            end else begin
              step_cnt_d = step_cnt_q + SCW'(1);
            end
`endif
          end
        end
      endcase
    end
  end

  // State and output registers; synchronous reset is resolved in the next-state logic
  always_ff @(posedge clk) begin
    state_q    <= state_d;
    lfsr_q     <= lfsr_d;
    step_cnt_q <= step_cnt_d;
    warm_cnt_q <= warm_cnt_d;
    out_valid  <= out_valid_d;
    out_data   <= out_data_d;
    lockup     <= lockup_d;
    warm       <= (state_d == ST_WARM);
  end

endmodule

// File: tb/tb_lfsr_rng_multi.sv
// Directed bench for lfsr_rng_multi: four 8-bit, 2-channel instances covering streaming,
// backpressure, decimation, zero seed, reseed during warm-up and all-zero repair.
module tb_lfsr_rng_multi;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, en, reseed;
  logic [7:0] seed;
  logic       rdy_a, rdy_b, rdy_c, rdy_d;
  logic       vld_a, vld_b, vld_c, vld_d;
  logic [15:0] dat_a, dat_b, dat_c, dat_d;
  logic       warm_a, warm_b, warm_c, warm_d;
  logic       lock_a, lock_b, lock_c, lock_d;

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

`ifdef LFSR_RNG_LEAP_EN
  localparam int unsigned B_GAP = 1;
`else
  localparam int unsigned B_GAP = 4;
`endif

  lfsr_rng_multi #(.LEN(8), .TAPS(8'hB8), .CHANNELS(2), .OUT_W(8), .STEPS(1), .WARMUP(0),
                   .SEED_STRIDE(8'h03)) u_a (
    .clk(clk), .rst(rst), .en(en), .reseed(reseed), .seed(seed), .out_ready(rdy_a),
    .out_valid(vld_a), .out_data(dat_a), .warm(warm_a), .lockup(lock_a));

  lfsr_rng_multi #(.LEN(8), .TAPS(8'hB8), .CHANNELS(2), .OUT_W(8), .STEPS(4), .WARMUP(0),
                   .SEED_STRIDE(8'h03)) u_b (
    .clk(clk), .rst(rst), .en(en), .reseed(reseed), .seed(seed), .out_ready(rdy_b),
    .out_valid(vld_b), .out_data(dat_b), .warm(warm_b), .lockup(lock_b));

  lfsr_rng_multi #(.LEN(8), .TAPS(8'hB8), .CHANNELS(2), .OUT_W(8), .STEPS(1), .WARMUP(3),
                   .SEED_STRIDE(8'h03)) u_c (
    .clk(clk), .rst(rst), .en(en), .reseed(reseed), .seed(seed), .out_ready(rdy_c),
    .out_valid(vld_c), .out_data(dat_c), .warm(warm_c), .lockup(lock_c));

  // Mask 8'h01 lets channel 1 (seed 8'h03) step straight into all-zero
  lfsr_rng_multi #(.LEN(8), .TAPS(8'h01), .CHANNELS(2), .OUT_W(8), .STEPS(1), .WARMUP(0),
                   .SEED_STRIDE(8'h02)) u_d (
    .clk(clk), .rst(rst), .en(en), .reseed(reseed), .seed(seed), .out_ready(rdy_d),
    .out_valid(vld_d), .out_data(dat_d), .warm(warm_d), .lockup(lock_d));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Bounded wait for the next B sample; checks the cycle gap and the word
  task automatic wait_sample_b(input string tag, input int unsigned gap, input logic [15:0] exp);
    int unsigned n = 0;
    do begin
      tick();
      n++;
    end while (!vld_b && n < 20);
    check({tag, " gap"}, n, gap);
    check({tag, " data"}, 32'({vld_b, dat_b}), 32'({1'b1, exp}));
  endtask

  logic [15:0] exp_a [4];

  initial begin
    exp_a = '{16'h01B8, 16'hB85C, 16'h5C2E, 16'h2E17};
    rst = 1'b1; en = 1'b0; reseed = 1'b0; seed = 8'h01;
    rdy_a = 1'b0; rdy_b = 1'b0; rdy_c = 1'b0; rdy_d = 1'b0;
    tick();
    tick();
    check("rst a out", 32'({vld_a, dat_a}), 32'd0);
    check("rst a lockup", 32'(lock_a), 32'd0);
    check("rst a warm", 32'(warm_a), 32'd0);
    check("rst c warm", 32'(warm_c), 32'd1);
    check("rst d lockup", 32'(lock_d), 32'd0);
    rst = 1'b0;

    // streaming one word per cycle; D hits zero after its first step
    en = 1'b1; rdy_a = 1'b1; rdy_b = 1'b1; rdy_d = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("stream a", 32'({vld_a, dat_a}), 32'({1'b1, exp_a[i]}));
      if (i == 0) check("lockup before repair", 32'(lock_d), 32'd0);
      if (i == 1) check("lockup after repair", 32'(lock_d), 32'd1);
    end
    check("warm c done", 32'(warm_c), 32'd0);
    check("c first sample", 32'({vld_c, dat_c}), 32'({1'b1, 16'h2E17}));

    // reseed while C holds an unconsumed sample
    reseed = 1'b1;
    tick();
    reseed = 1'b0;
    check("reseed c valid", 32'(vld_c), 32'd0);
    check("reseed c warm0", 32'(warm_c), 32'd1);
    check("reseed keeps lockup", 32'(lock_d), 32'd1);
    for (int i = 1; i < 3; i++) begin
      tick();
      check("reseed c warm", 32'(warm_c), 32'd1);
    end
    tick();
    check("reseed c run", 32'({warm_c, vld_c}), 32'd0);
    tick();
    check("reseed c sample", 32'({vld_c, dat_c}), 32'({1'b1, 16'h2E17}));

    // rst clears lockup, then backpressure on A
    en = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst clears lockup", 32'(lock_d), 32'd0);
    check("rst a cleared", 32'({vld_a, dat_a}), 32'd0);
    en = 1'b1; rdy_a = 1'b0;
    tick();
    check("bp first", 32'({vld_a, dat_a}), 32'({1'b1, 16'h01B8}));
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp hold", 32'({vld_a, dat_a}), 32'({1'b1, 16'h01B8}));
    end
    rdy_a = 1'b1;
    tick();
    check("bp release", 32'({vld_a, dat_a}), 32'({1'b1, 16'hB85C}));
    tick();
    check("bp next", 32'({vld_a, dat_a}), 32'({1'b1, 16'h5C2E}));

    // zero seed selects all-ones base
    en = 1'b0; seed = 8'h00; rst = 1'b1;
    tick();
    rst = 1'b0; en = 1'b1;
    tick();
    check("zero seed", 32'({vld_a, dat_a}), 32'({1'b1, 16'h7EC7}));

    // decimation by 4 on B
    en = 1'b0; seed = 8'h01; rst = 1'b1;
    tick();
    rst = 1'b0; rdy_b = 1'b1; en = 1'b1;
    wait_sample_b("steps4 first", B_GAP, 16'h2E17);
    wait_sample_b("steps4 second", B_GAP, 16'hC864);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
